stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control-side driver for the stopwatch's cascaded dec_ctr digit chain.
//  Turns start/stop, clear and preset buttons into the counter control bus:
//  cfg_cntr_mode, count_enb, load_cnt, load_value and ctr_reset_n.
//  A prescaler paces count_enb strobes; the chain's top carry_out returns as chain_carry.
// PARAMETERS
//  TICK_DIV  4  sys_clk cycles per count_enb strobe in RUN (>=2)
//  DIGITS    2  number of BCD digits in the counter chain (1..6)
// PORTS
//  sys_clk        in   1          single clock; all logic on its rising edge
//  reset          in   1          synchronous, active-high reset
//  btn_start      in   1          start/stop toggle; rising edge acts (already synchronised)
//  btn_clear      in   1          clear request; rising edge acts
//  btn_preset     in   1          load preset request; rising edge acts
//  dir_down       in   1          1 = count down, 0 = count up
//  preset_value   in   4*DIGITS   BCD preset, digit 0 in [3:0]
//  chain_carry    in   1          carry_out of most-significant dec_ctr (terminal count)
//  cfg_cntr_mode  out  1          to dec_ctr: 1 = up, 0 = down
//  count_enb      out  1          one-cycle count strobe
//  load_cnt       out  1          one-cycle parallel-load strobe
//  load_value     out  4*DIGITS   captured preset driven to the chain
//  ctr_reset_n    out  1          active-low clear to chain (one-cycle pulse)
//  done           out  1          one-cycle pulse on auto-stop (0 without AUTO_STOP_EN)
//  state_o        out  2          00 IDLE, 01 LOAD, 10 RUN, 11 PAUSE
// BEHAVIOUR
//  Reset (reset=1 at edge): state IDLE; count_enb=0, load_cnt=0, done=0; cfg_cntr_mode=1;
//   load_value=0; prescaler=0; ctr_reset_n=0 during reset, 1 from first cycle after.
//  Edge detect: registered copy of each button; event = btn & ~btn_q. Event acted on
//   the same edge it is detected; a held button produces exactly one event.
//  Priority of simultaneous events: clear > preset > start.
//  IDLE : start -> RUN; preset -> LOAD. dir_down sampled: cfg_cntr_mode <= ~dir_down.
//  LOAD : load_cnt=1 for exactly one cycle; load_value holds preset_value captured on the
//   preset event; next state PAUSE unconditionally (a start event here is dropped).
//  RUN  : prescaler counts 0..TICK_DIV-1; count_enb=1 in the cycle prescaler==TICK_DIV-1;
//   first strobe TICK_DIV cycles after RUN entry. start -> PAUSE (prescaler held, not
//   cleared). preset ignored. cfg_cntr_mode frozen; dir_down changes ignored.
//  PAUSE: count_enb=0; start -> RUN (prescaler resumes from held value); preset -> LOAD;
//   dir_down sampled into cfg_cntr_mode.
//  Clear event in any state: next state IDLE, ctr_reset_n=0 for exactly one cycle,
//   prescaler=0, count_enb/load_cnt forced 0 that cycle. Clear during LOAD aborts load.
//  Entering RUN from IDLE clears the prescaler; from PAUSE it does not.
//  count_enb and load_cnt are never 1 in the same cycle. All outputs registered.
//  Prescaler width = clog2(TICK_DIV); wraps TICK_DIV-1 -> 0 on every strobe.
// CONFIGURATION
//  STOPWATCH_AUTO_STOP_EN defined: in RUN, if chain_carry=1 in the cycle a strobe
//   would issue, the strobe is suppressed, state -> PAUSE, done=1 for one cycle;
//   chain holds at terminal (00..0 down, 99..9 up). Restart from PAUSE re-triggers
//   stop at next strobe point until cleared/preset.
//  Not defined: chain_carry ignored; strobes continue, chain wraps; done tied 0.
// TESTING (TICK_DIV=4, DIGITS=2)
//  Reset 3 cycles -> state_o=00, cfg_cntr_mode=1, ctr_reset_n=0 then 1, strobes 0.
//  preset_value=8'h37, pulse btn_preset in IDLE -> load_cnt=1 one cycle, load_value=8'h37, state_o=11.
//  btn_start held 10 cycles from IDLE -> single RUN entry; count_enb at cycles 4,8,12 after entry.
//  dir_down toggled in RUN -> cfg_cntr_mode unchanged; btn_start -> PAUSE, then dir_down=1 -> mode 0.
//  btn_clear and btn_preset same cycle in RUN -> IDLE, one-cycle ctr_reset_n=0, no load_cnt.
//  AUTO_STOP_EN, down, chain_carry=1 at strobe point -> no count_enb, done pulse, state_o=11.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edge detection, prescaled count strobes and load/clear control for a dec_ctr chain.
// Optional auto-stop at terminal count is enabled by defining STOPWATCH_AUTO_STOP_EN.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 4,
   parameter int DIGITS   = 2
) (
   input  logic                  sys_clk,
   input  logic                  reset,
   input  logic                  btn_start,
   input  logic                  btn_clear,
   input  logic                  btn_preset,
   input  logic                  dir_down,
   input  logic [4*DIGITS-1:0]   preset_value,
   input  logic                  chain_carry,
   output logic                  cfg_cntr_mode,
   output logic                  count_enb,
   output logic                  load_cnt,
   output logic [4*DIGITS-1:0]   load_value,
   output logic                  ctr_reset_n,
   output logic                  done,
   output logic [1:0]            state_o
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_RUN   = 2'b10,
      ST_PAUSE = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                start_q, clear_q, preset_q;
   logic                mode_q, mode_d;
   logic                count_enb_q, count_enb_d;
   logic                load_cnt_q, load_cnt_d;
   logic                done_q, done_d;
   logic                ctr_reset_n_q, ctr_reset_n_d;
   logic [4*DIGITS-1:0] load_value_q, load_value_d;

   logic start_ev, clear_ev, preset_ev;

   assign start_ev  = btn_start  & ~start_q;
   assign clear_ev  = btn_clear  & ~clear_q;
   assign preset_ev = btn_preset & ~preset_q;

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         presc_q       <= '0;
         start_q       <= 1'b0;
         clear_q       <= 1'b0;
         preset_q      <= 1'b0;
         mode_q        <= 1'b1;
         count_enb_q   <= 1'b0;
         load_cnt_q    <= 1'b0;
         done_q        <= 1'b0;
         ctr_reset_n_q <= 1'b0;
         load_value_q  <= '0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         start_q       <= btn_start;
         clear_q       <= btn_clear;
         preset_q      <= btn_preset;
         mode_q        <= mode_d;
         count_enb_q   <= count_enb_d;
         load_cnt_q    <= load_cnt_d;
         done_q        <= done_d;
         ctr_reset_n_q <= ctr_reset_n_d;
         load_value_q  <= load_value_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      presc_d       = presc_q;
      mode_d        = mode_q;
      count_enb_d   = 1'b0;
      load_cnt_d    = 1'b0;
      done_d        = 1'b0;
      ctr_reset_n_d = 1'b1;
      load_value_d  = load_value_q;

      // Direction is only tracked while the chain is not counting.
      if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
         mode_d = ~dir_down;
      end

      if (clear_ev) begin
         state_d       = ST_IDLE;
         presc_d       = '0;
         ctr_reset_n_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (preset_ev) begin
                  state_d      = ST_LOAD;
                  load_value_d = preset_value;
               end else if (start_ev) begin
                  state_d = ST_RUN;
                  presc_d = '0;
               end
            end
            // load_cnt issues on LOAD exit so a clear seen during LOAD can still abort it.
            ST_LOAD: begin
               state_d    = ST_PAUSE;
               load_cnt_d = 1'b1;
            end
            ST_RUN: begin
               if (start_ev) begin
                  state_d = ST_PAUSE;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
`ifdef STOPWATCH_AUTO_STOP_EN
                  if (chain_carry) begin
                     state_d = ST_PAUSE;
                     done_d  = 1'b1;
                  end else begin
                     count_enb_d = 1'b1;
                  end
`else
                  count_enb_d = 1'b1;
`endif
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            ST_PAUSE: begin
               if (preset_ev) begin
                  state_d      = ST_LOAD;
                  load_value_d = preset_value;
               end else if (start_ev) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifndef STOPWATCH_AUTO_STOP_EN
   logic unused_carry;
   assign unused_carry = chain_carry;
`endif

   assign cfg_cntr_mode = mode_q;
   assign count_enb     = count_enb_q;
   assign load_cnt      = load_cnt_q;
   assign load_value    = load_value_q;
   assign ctr_reset_n   = ctr_reset_n_q;
   assign done          = done_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized stimulus against a behavioural model.
module tb_stopwatch_ctrl;

   localparam int TD = 4;

   logic       sys_clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_start = 1'b0, btn_clear = 1'b0, btn_preset = 1'b0;
   logic       dir_down = 1'b0;
   logic [7:0] preset_value = 8'h00;
   logic       chain_carry = 1'b0;
   logic       cfg_cntr_mode, count_enb, load_cnt, ctr_reset_n, done;
   logic [7:0] load_value;
   logic [1:0] state_o;

   int checks = 0;
   int failures = 0;

   // behavioural model state
   int         m_st = 0;
   int         m_run = 0;
   bit         m_bs = 0, m_bc = 0, m_bp = 0;
   bit         e_mode = 1, e_ce = 0, e_lc = 0, e_rn = 0, e_done = 0;
   logic [7:0] e_lv = 8'h00;

   localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_PAUSE = 3;

   stopwatch_ctrl #(.TICK_DIV(TD), .DIGITS(2)) dut (
      .sys_clk(sys_clk), .reset(reset),
      .btn_start(btn_start), .btn_clear(btn_clear), .btn_preset(btn_preset),
      .dir_down(dir_down), .preset_value(preset_value), .chain_carry(chain_carry),
      .cfg_cntr_mode(cfg_cntr_mode), .count_enb(count_enb), .load_cnt(load_cnt),
      .load_value(load_value), .ctr_reset_n(ctr_reset_n), .done(done), .state_o(state_o)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic model_step();
      bit ev_s, ev_c, ev_p;
      int old;
      if (reset) begin
         m_st = S_IDLE; m_run = 0; m_bs = 0; m_bc = 0; m_bp = 0;
         e_mode = 1; e_ce = 0; e_lc = 0; e_rn = 0; e_done = 0; e_lv = 8'h00;
         return;
      end
      ev_s = btn_start && !m_bs;
      ev_c = btn_clear && !m_bc;
      ev_p = btn_preset && !m_bp;
      m_bs = btn_start; m_bc = btn_clear; m_bp = btn_preset;
      e_ce = 0; e_lc = 0; e_done = 0; e_rn = 1;
      old = m_st;
      if (old == S_IDLE || old == S_PAUSE) e_mode = !dir_down;
      if (ev_c) begin
         m_st = S_IDLE; m_run = 0; e_rn = 0;
      end else if (old == S_LOAD) begin
         m_st = S_PAUSE; e_lc = 1;
      end else if (old == S_RUN) begin
         if (ev_s) m_st = S_PAUSE;
         else begin
            if (m_run % TD == TD - 1) begin
`ifdef STOPWATCH_AUTO_STOP_EN
               if (chain_carry) begin m_st = S_PAUSE; e_done = 1; end
               else e_ce = 1;
`else
               e_ce = 1;
`endif
            end
            m_run = m_run + 1;
         end
      end else begin
         if (ev_p) begin
            m_st = S_LOAD; e_lv = preset_value;
         end else if (ev_s) begin
            if (old == S_IDLE) m_run = 0;
            m_st = S_RUN;
         end
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL reset_state got=%b want=00", state_o); end
      checks++; if (cfg_cntr_mode !== 1'b1) begin failures++; $display("FAIL reset_mode got=%b want=1", cfg_cntr_mode); end
      checks++; if (ctr_reset_n !== 1'b0) begin failures++; $display("FAIL reset_rn_low got=%b want=0", ctr_reset_n); end
      checks++; if ({count_enb, load_cnt, done} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b want=000", {count_enb, load_cnt, done}); end
      checks++; if (load_value !== 8'h00) begin failures++; $display("FAIL reset_lv got=%h want=00", load_value); end
      reset = 1'b0;
      tick();
      checks++; if (ctr_reset_n !== 1'b1) begin failures++; $display("FAIL reset_rn_high got=%b want=1", ctr_reset_n); end
      $display("reset: state=%b mode=%b rn=%b", state_o, cfg_cntr_mode, ctr_reset_n);
   endtask

   task automatic test_preset();
      preset_value = 8'h37;
      btn_preset = 1'b1;
      tick();
      btn_preset = 1'b0;
      checks++; if (state_o !== 2'b01 || load_cnt !== 1'b0) begin failures++; $display("FAIL preset_load_state got=%b/%b want=01/0", state_o, load_cnt); end
      tick();
      checks++; if (load_cnt !== 1'b1) begin failures++; $display("FAIL preset_load_cnt got=%b want=1", load_cnt); end
      checks++; if (load_value !== 8'h37) begin failures++; $display("FAIL preset_value got=%h want=37", load_value); end
      checks++; if (state_o !== 2'b11) begin failures++; $display("FAIL preset_pause got=%b want=11", state_o); end
      tick();
      checks++; if (load_cnt !== 1'b0) begin failures++; $display("FAIL preset_one_cycle got=%b want=0", load_cnt); end
      $display("preset: load_value=%h state=%b", load_value, state_o);
   endtask

   task automatic test_start_held();
      btn_clear = 1'b1;
      tick();
      btn_clear = 1'b0;
      checks++; if (state_o !== 2'b00 || ctr_reset_n !== 1'b0) begin failures++; $display("FAIL clear_pulse got=%b/%b want=00/0", state_o, ctr_reset_n); end
      tick();
      checks++; if (ctr_reset_n !== 1'b1) begin failures++; $display("FAIL clear_release got=%b want=1", ctr_reset_n); end
      btn_start = 1'b1;
      tick();
      checks++; if (state_o !== 2'b10) begin failures++; $display("FAIL run_entry got=%b want=10", state_o); end
      for (int i = 1; i <= 13; i++) begin
         if (i == 10) btn_start = 1'b0;
         tick();
         checks++;
         if (count_enb !== ((i % 4) == 0) || state_o !== 2'b10) begin
            failures++;
            $display("FAIL start_held_c%0d got=ce%b/st%b want=ce%b/st10", i, count_enb, state_o, (i % 4) == 0);
         end
      end
      $display("start_held: state=%b after 13 cycles", state_o);
   endtask

   task automatic test_dir();
      for (int i = 0; i < 5; i++) begin
         dir_down = ~dir_down;
         tick();
         checks++; if (cfg_cntr_mode !== 1'b1) begin failures++; $display("FAIL dir_frozen_%0d got=%b want=1", i, cfg_cntr_mode); end
      end
      dir_down = 1'b0;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      checks++; if (state_o !== 2'b11) begin failures++; $display("FAIL dir_pause got=%b want=11", state_o); end
      dir_down = 1'b1;
      tick();
      checks++; if (cfg_cntr_mode !== 1'b0) begin failures++; $display("FAIL dir_sampled got=%b want=0", cfg_cntr_mode); end
      $display("dir: mode=%b state=%b", cfg_cntr_mode, state_o);
   endtask

   task automatic test_clear_preset();
      dir_down = 1'b0;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      checks++; if (state_o !== 2'b10) begin failures++; $display("FAIL resume_run got=%b want=10", state_o); end
      repeat (3) tick();
      btn_clear = 1'b1; btn_preset = 1'b1;
      tick();
      btn_clear = 1'b0; btn_preset = 1'b0;
      checks++; if (state_o !== 2'b00 || ctr_reset_n !== 1'b0) begin failures++; $display("FAIL clr_pre_state got=%b/%b want=00/0", state_o, ctr_reset_n); end
      checks++; if (load_cnt !== 1'b0 || count_enb !== 1'b0) begin failures++; $display("FAIL clr_pre_strobes got=%b%b want=00", load_cnt, count_enb); end
      tick();
      checks++; if (ctr_reset_n !== 1'b1 || load_cnt !== 1'b0 || state_o !== 2'b00) begin failures++; $display("FAIL clr_pre_after got=%b/%b/%b want=1/0/00", ctr_reset_n, load_cnt, state_o); end
      $display("clear_preset: state=%b rn=%b", state_o, ctr_reset_n);
   endtask

   task automatic test_back_to_back();
      preset_value = 8'h52;
      btn_preset = 1'b1;
      tick();
      btn_preset = 1'b0;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      checks++; if (state_o !== 2'b11 || load_cnt !== 1'b1) begin failures++; $display("FAIL b2b_drop_start got=%b/%b want=11/1", state_o, load_cnt); end
      tick();
      checks++; if (load_value !== 8'h52 || state_o !== 2'b11) begin failures++; $display("FAIL b2b_hold got=%h/%b want=52/11", load_value, state_o); end
      $display("back_to_back: state=%b load_value=%h", state_o, load_value);
   endtask

   task automatic test_auto_stop();
      btn_clear = 1'b1;
      tick();
      btn_clear = 1'b0;
      dir_down = 1'b1;
      tick();
      checks++; if (cfg_cntr_mode !== 1'b0) begin failures++; $display("FAIL as_mode got=%b want=0", cfg_cntr_mode); end
      chain_carry = 1'b1;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
`ifdef STOPWATCH_AUTO_STOP_EN
         if (count_enb !== 1'b0 || done !== (i == 4) || state_o !== ((i == 4) ? 2'b11 : 2'b10)) begin
            failures++; $display("FAIL auto_stop_c%0d got=ce%b/done%b/st%b", i, count_enb, done, state_o);
         end
`else
         if (count_enb !== (i == 4) || done !== 1'b0 || state_o !== 2'b10) begin
            failures++; $display("FAIL no_auto_stop_c%0d got=ce%b/done%b/st%b", i, count_enb, done, state_o);
         end
`endif
      end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b want=0", done); end
      chain_carry = 1'b0;
      $display("auto_stop: state=%b done=%b", state_o, done);
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset        = ($urandom_range(0, 149) == 0);
         btn_start    = ($urandom_range(0, 5) == 0);
         btn_clear    = ($urandom_range(0, 29) == 0);
         btn_preset   = ($urandom_range(0, 11) == 0);
         dir_down     = $urandom_range(0, 1) != 0;
         chain_carry  = ($urandom_range(0, 3) == 0);
         preset_value = 8'($urandom);
         tick();
         checks++;
         if (state_o !== 2'(m_st) || count_enb !== e_ce || load_cnt !== e_lc || done !== e_done ||
             ctr_reset_n !== e_rn || cfg_cntr_mode !== e_mode || load_value !== e_lv) begin
            failures++;
            $display("FAIL random_c%0d got=st%b ce%b lc%b dn%b rn%b md%b lv%h want=st%0d ce%b lc%b dn%b rn%b md%b lv%h",
                     i, state_o, count_enb, load_cnt, done, ctr_reset_n, cfg_cntr_mode, load_value,
                     m_st, e_ce, e_lc, e_done, e_rn, e_mode, e_lv);
         end
      end
      reset = 1'b0;
      $display("random: 600 cycles compared against model");
   endtask

   initial begin
      test_reset();
      test_preset();
      test_start_held();
      test_dir();
      test_clear_preset();
      test_back_to_back();
      test_auto_stop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
